// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage constants and FSM state encoding.
// Imported by fetch_stage and fetch_hold_buf.
package fetch_stage_pkg;

  localparam int unsigned XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_FULL = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry instr+pc skid register used while decode is stalled.
// Clear has priority over write, write over read.
module fetch_hold_buf #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr,
  input  logic            rd,
  input  logic            clr,
  input  logic [XLEN-1:0] wr_instr,
  input  logic [XLEN-1:0] wr_pc,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic            hold_valid
);
  import fetch_stage_pkg::*;

  // Capture a stalled response, drop it on consume or redirect
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_valid <= 1'b0;
      instr      <= XLEN'(NOP_INSTR);
      pc         <= '0;
    end else if (clr) begin
      hold_valid <= 1'b0;
    end else if (wr) begin
      hold_valid <= 1'b1;
      instr      <= wr_instr;
      pc         <= wr_pc;
    end else if (rd) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC generation, single-outstanding imem handshake, IF/ID reg.
// FETCH_PERF_CNT_EN adds fetch_count/stall_count outputs.
module fetch_stage #(
  parameter int unsigned     XLEN     = fetch_stage_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = fetch_stage_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr_ID,
  output logic [XLEN-1:0] pc_ID,
  output logic            valid_ID
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] fetch_count,
  output logic [XLEN-1:0] stall_count
`endif
);
  import fetch_stage_pkg::*;

  localparam logic [XLEN-1:0] NOP = XLEN'(NOP_INSTR);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_inflight;
  logic            kill;
  logic            redirect;
  logic [XLEN-1:0] fpc;
  logic [XLEN-1:0] nxt_pc;
  logic            rsp_ok;
  logic            hold_valid;
  logic            hold_wr;
  logic            hold_rd;
  logic [XLEN-1:0] hold_instr;
  logic [XLEN-1:0] hold_pc;

  assign fpc     = flush_pc & ~XLEN'(3);
  assign nxt_pc  = flush ? fpc : pc;
  assign rsp_ok  = (state == FETCH_WAIT) && imem_rvalid
                   && !kill && !flush;
  assign hold_wr = stall && rsp_ok;
  assign hold_rd = !flush && !stall && hold_valid;

  fetch_hold_buf #(
    .XLEN(XLEN)
  ) u_hold (
    .clk       (clk),
    .reset     (reset),
    .wr        (hold_wr),
    .rd        (hold_rd),
    .clr       (flush),
    .wr_instr  (imem_rdata),
    .wr_pc     (pc_inflight),
    .instr     (hold_instr),
    .pc        (hold_pc),
    .hold_valid(hold_valid)
  );

  // Request FSM: one outstanding fetch, redirect and kill tracking
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= FETCH_REQ;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      pc          <= RESET_PC;
      pc_inflight <= RESET_PC;
      redirect    <= 1'b0;
      kill        <= (state == FETCH_WAIT)
                     || (imem_req && imem_gnt);
    end else begin
      unique case (state)
        FETCH_REQ: begin
          if (!imem_req) begin
            imem_req  <= 1'b1;
            imem_addr <= nxt_pc;
            pc        <= nxt_pc;
            if (imem_rvalid) kill <= 1'b0;
          end else if (imem_gnt) begin
            state       <= FETCH_WAIT;
            imem_req    <= 1'b0;
            pc_inflight <= imem_addr;
            redirect    <= 1'b0;
            kill        <= flush || redirect
                           || (kill && !imem_rvalid);
            pc          <= (flush || redirect) ? nxt_pc
                           : pc + XLEN'(4);
          end else begin
            pc       <= nxt_pc;
            redirect <= redirect || flush;
            if (imem_rvalid) kill <= 1'b0;
          end
        end
        FETCH_WAIT: begin
          if (imem_rvalid) begin
            kill <= 1'b0;
            pc   <= nxt_pc;
            if (rsp_ok && stall) begin
              state <= FETCH_FULL;
            end else begin
              state     <= FETCH_REQ;
              imem_req  <= 1'b1;
              imem_addr <= nxt_pc;
            end
          end else if (flush) begin
            kill <= 1'b1;
            pc   <= nxt_pc;
          end
        end
        FETCH_FULL: begin
          pc <= nxt_pc;
          if (flush || !stall) begin
            state     <= FETCH_REQ;
            imem_req  <= 1'b1;
            imem_addr <= nxt_pc;
          end
        end
        default: begin
          state    <= FETCH_REQ;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // IF/ID register: flush > stall > hold entry > response > bubble
  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_ID <= NOP;
      pc_ID    <= '0;
      valid_ID <= 1'b0;
    end else if (flush) begin
      instr_ID <= NOP;
      valid_ID <= 1'b0;
    end else if (!stall) begin
      if (hold_valid) begin
        instr_ID <= hold_instr;
        pc_ID    <= hold_pc;
        valid_ID <= 1'b1;
      end else if (rsp_ok) begin
        instr_ID <= imem_rdata;
        pc_ID    <= pc_inflight;
        valid_ID <= 1'b1;
      end else begin
        instr_ID <= NOP;
        valid_ID <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic load_v;
  assign load_v = !flush && !stall && (hold_valid || rsp_ok);

  // Free-running counters of valid IF/ID loads and stall cycles
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (load_v) fetch_count <= fetch_count + XLEN'(1);
      if (stall)  stall_count <= stall_count + XLEN'(1);
    end
  end
`endif

endmodule
